cr_prefix_attach_pmc: RTL and testbench

CR_PREFIX_ATTACH_PMC -- requirements
Module: cr_prefix_attach_pmc

---
 rtl/cr_prefix_attach_pmc_pkg.sv | 20 ++
 rtl/cr_prefix_attach_pmc_if.sv | 40 ++++
 rtl/cr_prefix_attach_pmc_crc.sv | 23 ++
 rtl/cr_prefix_attach_pmc.sv | 144 ++++++++++++++
 tb/tb_cr_prefix_attach_pmc.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cr_prefix_attach_pmc_pkg.sv
// Shared types and constants for the prefix attach memory controller (PMC):
// FSM state encoding, default prefix sizes and the CRC-32 constants.
package cr_prefix_attachPKG;

    localparam int N_PHD_DEFAULT = 8;
    localparam int N_PFD_DEFAULT = 64;

    localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        DRAIN = 3'd2,
        EOT   = 3'd3,
        WAIT  = 3'd4
    } pmc_state_e;

endpackage

// File: rtl/cr_prefix_attach_pmc_if.sv
// Bundle of the PMC control, memory read and status signals.
// master: the PMC side.  slave: the insertion logic / memories / consumer side.
interface cr_prefix_attach_pmc_if;

    logic        pti_insert_phd_inwrk;
    logic        pti_insert_pfd_inwrk;
    logic [5:0]  ibp_prefix_num;
    logic        usr_ob_afull;

    logic        phd_mem_rd;
    logic [8:0]  phd_mem_addr;
    logic [63:0] phd_mem_dout;
    logic        pfd_mem_rd;
    logic [11:0] pfd_mem_addr;
    logic [63:0] pfd_mem_dout;

    logic        pmc_phd_dout_valid;
    logic        pmc_pfd_dout_valid;
    logic        pmc_phd_eot;
    logic        pmc_pfd_eot;
    logic [31:0] pmc_phd_crc;
    logic [31:0] pmc_pfd_crc;

    modport master (
        input  pti_insert_phd_inwrk, pti_insert_pfd_inwrk, ibp_prefix_num, usr_ob_afull,
        input  phd_mem_dout, pfd_mem_dout,
        output phd_mem_rd, phd_mem_addr, pfd_mem_rd, pfd_mem_addr,
        output pmc_phd_dout_valid, pmc_pfd_dout_valid, pmc_phd_eot, pmc_pfd_eot,
        output pmc_phd_crc, pmc_pfd_crc
    );

    modport slave (
        output pti_insert_phd_inwrk, pti_insert_pfd_inwrk, ibp_prefix_num, usr_ob_afull,
        output phd_mem_dout, pfd_mem_dout,
        input  phd_mem_rd, phd_mem_addr, pfd_mem_rd, pfd_mem_addr,
        input  pmc_phd_dout_valid, pmc_pfd_dout_valid, pmc_phd_eot, pmc_pfd_eot,
        input  pmc_phd_crc, pmc_pfd_crc
    );

endinterface

// File: rtl/cr_prefix_attach_pmc_crc.sv
// One combinational CRC-32 step over a 64-bit word, reflected form,
// consuming data bit 0 first (so byte [7:0] first through [63:56]).
module cr_prefix_attach_pmc_crc
    import cr_prefix_attachPKG::*;
(
    input  logic [31:0] crc_in,
    input  logic [63:0] data_in,
    output logic [31:0] crc_out
);

    // Bit-serial LFSR unrolled across all 64 data bits
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 64; i++) begin
            if (crc_out[0] ^ data_in[i]) begin
                crc_out = (crc_out >> 1) ^ CRC32_POLY;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/cr_prefix_attach_pmc.sv
// Prefix attach memory controller: reads one prefix's PHD or PFD words from
// memory, flags returning data, pulses eot after the last word and optionally
// accumulates a CRC-32 over the returned words.
// Optional feature: define CR_PREFIX_PMC_CRC_EN to build the CRC logic;
// otherwise both CRC outputs are tied to zero.
module cr_prefix_attach_pmc
    import cr_prefix_attachPKG::*;
#(
    parameter int N_PHD_WORDS = N_PHD_DEFAULT,
    parameter int N_PFD_WORDS = N_PFD_DEFAULT
) (
    input logic clk,
    input logic rst_n,
    cr_prefix_attach_pmc_if.master bus
);

    localparam int N_MAX = (N_PHD_WORDS > N_PFD_WORDS) ? N_PHD_WORDS : N_PFD_WORDS;
    localparam int CNT_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;

    pmc_state_e       state;
    pmc_state_e       state_next;
    logic             ch_phd;
    logic [5:0]       prefix_q;
    logic [CNT_W-1:0] word_cnt;
    logic             valid_q;

    logic any_inwrk;
    logic sel_inwrk;
    logic start;
    logic abort;
    logic last_word;
    logic rd_issue;
    logic valid_now;

    assign any_inwrk = bus.pti_insert_phd_inwrk | bus.pti_insert_pfd_inwrk;
    assign sel_inwrk = ch_phd ? bus.pti_insert_phd_inwrk : bus.pti_insert_pfd_inwrk;
    assign start     = (state == IDLE) && any_inwrk;
    assign abort     = ((state == RD) || (state == DRAIN)) && !sel_inwrk;
    assign last_word = ch_phd ? (word_cnt == CNT_W'(N_PHD_WORDS - 1))
                              : (word_cnt == CNT_W'(N_PFD_WORDS - 1));

    // Addresses are combinational so they hold naturally while the counter is stalled
    assign bus.phd_mem_addr = 9'(32'(prefix_q) * 32'(N_PHD_WORDS) + 32'(word_cnt));
    assign bus.pfd_mem_addr = 12'(32'(prefix_q) * 32'(N_PFD_WORDS) + 32'(word_cnt));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: abort wins over progress; WAIT blocks restart on stale inwrk
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_inwrk) state_next = RD;
            RD: begin
                if (abort)                      state_next = IDLE;
                else if (rd_issue && last_word) state_next = DRAIN;
            end
            DRAIN: begin
                if (abort)          state_next = IDLE;
                else if (valid_now) state_next = EOT;
            end
            EOT:     state_next = WAIT;
            WAIT:    if (!any_inwrk) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: strobes, valids and eot steered to the latched channel only
    always_comb begin
        rd_issue  = (state == RD) && !bus.usr_ob_afull && sel_inwrk;
        valid_now = valid_q && !abort;
        bus.phd_mem_rd         = rd_issue && ch_phd;
        bus.pfd_mem_rd         = rd_issue && !ch_phd;
        bus.pmc_phd_dout_valid = valid_now && ch_phd;
        bus.pmc_pfd_dout_valid = valid_now && !ch_phd;
        bus.pmc_phd_eot        = (state == EOT) && ch_phd;
        bus.pmc_pfd_eot        = (state == EOT) && !ch_phd;
    end

    // Transfer context: channel/prefix latch, saturating word counter, 1-cycle read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_phd   <= 1'b0;
            prefix_q <= '0;
            word_cnt <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= rd_issue;
            if (start) begin
                ch_phd   <= bus.pti_insert_phd_inwrk;
                prefix_q <= bus.ibp_prefix_num;
                word_cnt <= '0;
            end else if (rd_issue && !last_word) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

`ifdef CR_PREFIX_PMC_CRC_EN
    logic [31:0] crc_phd_q;
    logic [31:0] crc_pfd_q;
    logic [31:0] crc_cur;
    logic [31:0] crc_next;
    logic [63:0] data_sel;

    assign crc_cur  = ch_phd ? crc_phd_q : crc_pfd_q;
    assign data_sel = ch_phd ? bus.phd_mem_dout : bus.pfd_mem_dout;

    cr_prefix_attach_pmc_crc u_crc (
        .crc_in  (crc_cur),
        .data_in (data_sel),
        .crc_out (crc_next)
    );

    // Per-channel running CRC; reset to the init value so the reported CRC reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_phd_q <= CRC32_INIT;
            crc_pfd_q <= CRC32_INIT;
        end else if (start) begin
            if (bus.pti_insert_phd_inwrk) crc_phd_q <= CRC32_INIT;
            else                          crc_pfd_q <= CRC32_INIT;
        end else if (valid_now) begin
            if (ch_phd) crc_phd_q <= crc_next;
            else        crc_pfd_q <= crc_next;
        end
    end

    assign bus.pmc_phd_crc = crc_phd_q ^ CRC32_XOROUT;
    assign bus.pmc_pfd_crc = crc_pfd_q ^ CRC32_XOROUT;
`else
    logic unused_dout;
    assign unused_dout     = ^{bus.phd_mem_dout, bus.pfd_mem_dout};
    assign bus.pmc_phd_crc = '0;
    assign bus.pmc_pfd_crc = '0;
`endif

endmodule

// File: tb/tb_cr_prefix_attach_pmc.sv
// Self-checking bench for cr_prefix_attach_pmc with behavioural memories and a
// byte-wise CRC-32 reference. CRC expectations follow CR_PREFIX_PMC_CRC_EN.
module tb_cr_prefix_attach_pmc;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cr_prefix_attach_pmc_if bus ();

    cr_prefix_attach_pmc #(
        .N_PHD_WORDS (8),
        .N_PFD_WORDS (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [63:0] phd_mem [0:511];
    logic [63:0] pfd_mem [0:4095];

    int checks = 0;
    int fails  = 0;

    // Monitor state, cleared per transfer
    int mon_phd_rd, mon_pfd_rd, mon_phd_val, mon_pfd_val, mon_phd_eot, mon_pfd_eot;
    int mon_cyc, mon_last_val, mon_eot_cyc, mon_rd_afull, mon_rd_after_eot, mon_hold_err;
    logic [31:0] mon_crc_eot;
    int addr_q[$];
    bit mon_phd;
    bit mon_prev_afull;
    logic [11:0] mon_prev_addr;
    logic [11:0] mon_cur;

    // Memories with one cycle of read latency
    always @(posedge clk) begin
        if (bus.phd_mem_rd) bus.phd_mem_dout <= phd_mem[bus.phd_mem_addr];
        if (bus.pfd_mem_rd) bus.pfd_mem_dout <= pfd_mem[bus.pfd_mem_addr];
    end

    // Observe outputs mid-cycle
    always @(negedge clk) begin
        mon_cyc++;
        if (bus.phd_mem_rd || bus.pfd_mem_rd) begin
            if (bus.usr_ob_afull) mon_rd_afull++;
            if ((mon_phd_eot + mon_pfd_eot) > 0) mon_rd_after_eot++;
        end
        if (bus.phd_mem_rd) begin mon_phd_rd++; addr_q.push_back(int'(bus.phd_mem_addr)); end
        if (bus.pfd_mem_rd) begin mon_pfd_rd++; addr_q.push_back(int'(bus.pfd_mem_addr)); end
        if (bus.pmc_phd_dout_valid) begin mon_phd_val++; mon_last_val = mon_cyc; end
        if (bus.pmc_pfd_dout_valid) begin mon_pfd_val++; mon_last_val = mon_cyc; end
        if (bus.pmc_phd_eot) begin mon_phd_eot++; mon_eot_cyc = mon_cyc; mon_crc_eot = bus.pmc_phd_crc; end
        if (bus.pmc_pfd_eot) begin mon_pfd_eot++; mon_eot_cyc = mon_cyc; mon_crc_eot = bus.pmc_pfd_crc; end
        mon_cur = mon_phd ? 12'(bus.phd_mem_addr) : bus.pfd_mem_addr;
        if (bus.usr_ob_afull && mon_prev_afull && (mon_cur != mon_prev_addr)) mon_hold_err++;
        mon_prev_addr  = mon_cur;
        mon_prev_afull = bus.usr_ob_afull;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearMon(input bit phd);
        mon_phd = phd;
        mon_phd_rd = 0; mon_pfd_rd = 0; mon_phd_val = 0; mon_pfd_val = 0;
        mon_phd_eot = 0; mon_pfd_eot = 0; mon_cyc = 0; mon_last_val = 0; mon_eot_cyc = 0;
        mon_rd_afull = 0; mon_rd_after_eot = 0; mon_hold_err = 0; mon_crc_eot = '0;
        mon_prev_afull = 1'b0;
        addr_q.delete();
    endtask

    // Reference CRC-32: classic reflected byte-at-a-time form
    function automatic logic [31:0] crcWord(input logic [31:0] c_in, input logic [63:0] d);
        logic [31:0] c;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            c = c ^ {24'h0, d[8*b +: 8]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] modelCrc(input bit is_phd, input int prefix, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int w = 0; w < n; w++)
            c = crcWord(c, is_phd ? phd_mem[prefix * 8 + w] : pfd_mem[prefix * 64 + w]);
        return c ^ 32'hFFFFFFFF;
    endfunction

    // One transfer: stall_mode 0 none, 1 fixed window, 2 random; abort_after>0 drops inwrk after that many reads
    task automatic applyStimulus(input bit is_phd, input bit both, input int prefix, input int stall_mode,
                                 input int stall_at, input int stall_len, input int hold_after,
                                 input int abort_after);
        int n, cyc, exp_rd, exp_val, own_rd, oth_rd, own_val, oth_val, own_eot, oth_eot;
        bit done, aborted;
        logic [31:0] exp_crc, crc_now;
        n = is_phd ? 8 : 64;
        clearMon(is_phd);
        bus.ibp_prefix_num       = 6'(prefix);
        bus.pti_insert_phd_inwrk = is_phd || both;
        bus.pti_insert_pfd_inwrk = !is_phd || both;
        cyc = 0; done = 0; aborted = 0;
        while (!done && cyc < 1000) begin
            tick();
            cyc++;
            case (stall_mode)
                1:       bus.usr_ob_afull = (cyc >= stall_at) && (cyc < stall_at + stall_len);
                2:       bus.usr_ob_afull = (cyc >= 2) && ($urandom_range(0, 3) == 0);
                default: bus.usr_ob_afull = 1'b0;
            endcase
            if (abort_after > 0 && (mon_phd_rd + mon_pfd_rd) >= abort_after) begin
                bus.pti_insert_phd_inwrk = 1'b0;
                bus.pti_insert_pfd_inwrk = 1'b0;
                bus.usr_ob_afull = 1'b0;
                aborted = 1; done = 1;
            end
            if ((mon_phd_eot + mon_pfd_eot) > 0) begin
                bus.usr_ob_afull = 1'b0;
                done = 1;
            end
        end
        if (!done) checkOutput("eot_timeout", 64'd0, 64'd1);
        if (!aborted) repeat (hold_after) tick();
        bus.pti_insert_phd_inwrk = 1'b0;
        bus.pti_insert_pfd_inwrk = 1'b0;
        bus.usr_ob_afull = 1'b0;
        repeat (6) tick();

        exp_rd  = aborted ? abort_after : n;
        exp_val = aborted ? abort_after - 1 : n;
        own_rd  = is_phd ? mon_phd_rd  : mon_pfd_rd;   oth_rd  = is_phd ? mon_pfd_rd  : mon_phd_rd;
        own_val = is_phd ? mon_phd_val : mon_pfd_val;  oth_val = is_phd ? mon_pfd_val : mon_phd_val;
        own_eot = is_phd ? mon_phd_eot : mon_pfd_eot;  oth_eot = is_phd ? mon_pfd_eot : mon_phd_eot;
        checkOutput("rd_count", 64'(own_rd), 64'(exp_rd));
        checkOutput("other_rd_count", 64'(oth_rd), 64'd0);
        for (int i = 0; i < exp_rd; i++)
            checkOutput("rd_addr", (i < addr_q.size()) ? 64'(addr_q[i]) : 64'hFFFF, 64'(prefix * n + i));
        checkOutput("valid_count", 64'(own_val), 64'(exp_val));
        checkOutput("other_valid_count", 64'(oth_val), 64'd0);
        checkOutput("eot_count", 64'(own_eot), aborted ? 64'd0 : 64'd1);
        checkOutput("other_eot_count", 64'(oth_eot), 64'd0);
        checkOutput("rd_during_stall", 64'(mon_rd_afull), 64'd0);
        checkOutput("addr_hold", 64'(mon_hold_err), 64'd0);
        checkOutput("rd_after_eot", 64'(mon_rd_after_eot), 64'd0);
        if (!aborted) begin
`ifdef CR_PREFIX_PMC_CRC_EN
            exp_crc = modelCrc(is_phd, prefix, n);
`else
            exp_crc = 32'h0;
`endif
            crc_now = is_phd ? bus.pmc_phd_crc : bus.pmc_pfd_crc;
            checkOutput("eot_after_last_valid", 64'(mon_eot_cyc - mon_last_val), 64'd1);
            checkOutput("crc_at_eot", 64'(mon_crc_eot), 64'(exp_crc));
            checkOutput("crc_hold", 64'(crc_now), 64'(exp_crc));
        end
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 512; i++)  phd_mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 4096; i++) pfd_mem[i] = {$urandom, $urandom};
        rst_n = 1'b0;
        bus.pti_insert_phd_inwrk = 1'b0;
        bus.pti_insert_pfd_inwrk = 1'b0;
        bus.ibp_prefix_num = '0;
        bus.usr_ob_afull = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_phd_rd",    64'(bus.phd_mem_rd), 64'd0);
        checkOutput("rst_pfd_rd",    64'(bus.pfd_mem_rd), 64'd0);
        checkOutput("rst_phd_addr",  64'(bus.phd_mem_addr), 64'd0);
        checkOutput("rst_pfd_addr",  64'(bus.pfd_mem_addr), 64'd0);
        checkOutput("rst_phd_valid", 64'(bus.pmc_phd_dout_valid), 64'd0);
        checkOutput("rst_pfd_valid", 64'(bus.pmc_pfd_dout_valid), 64'd0);
        checkOutput("rst_phd_eot",   64'(bus.pmc_phd_eot), 64'd0);
        checkOutput("rst_pfd_eot",   64'(bus.pmc_pfd_eot), 64'd0);
        checkOutput("rst_phd_crc",   64'(bus.pmc_phd_crc), 64'd0);
        checkOutput("rst_pfd_crc",   64'(bus.pmc_pfd_crc), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("[TB] PHD prefix 3, no stall");
        applyStimulus(1, 0, 3, 0, 0, 0, 0, 0);
        $display("[TB] PFD prefix 63, no stall");
        applyStimulus(0, 0, 63, 0, 0, 0, 0, 0);
        $display("[TB] PFD prefix 63, 5-cycle stall");
        applyStimulus(0, 0, 63, 1, 10, 5, 0, 0);
        $display("[TB] inwrk held 2 cycles after eot");
        applyStimulus(1, 0, 5, 0, 0, 0, 2, 0);
        $display("[TB] abort after 3 PHD reads, then restart");
        applyStimulus(1, 0, 7, 0, 0, 0, 0, 3);
        applyStimulus(1, 0, 7, 0, 0, 0, 0, 0);
        $display("[TB] both inwrk together");
        applyStimulus(1, 1, 12, 0, 0, 0, 1, 0);

        $display("[TB] randomized transfers");
        for (int k = 0; k < 10; k++) begin
            bit ph;
            ph = 1'($urandom_range(0, 1));
            applyStimulus(ph, 0, int'($urandom_range(0, 63)), 2, 0, 0, int'($urandom_range(0, 3)), 0);
        end

        $display("[TB] reset mid-transfer");
        clearMon(0);
        bus.ibp_prefix_num = 6'd20;
        bus.pti_insert_pfd_inwrk = 1'b1;
        cyc = 0;
        while (mon_pfd_rd < 5 && cyc < 200) begin tick(); cyc++; end
        checkOutput("midrst_reads_seen", 64'(mon_pfd_rd), 64'd5);
        rst_n = 1'b0;
        bus.pti_insert_pfd_inwrk = 1'b0;
        @(negedge clk);
        checkOutput("midrst_pfd_rd",    64'(bus.pfd_mem_rd), 64'd0);
        checkOutput("midrst_pfd_addr",  64'(bus.pfd_mem_addr), 64'd0);
        checkOutput("midrst_pfd_valid", 64'(bus.pmc_pfd_dout_valid), 64'd0);
        checkOutput("midrst_pfd_crc",   64'(bus.pmc_pfd_crc), 64'd0);
        tick();
        rst_n = 1'b1;
        clearMon(0);
        repeat (30) tick();
        checkOutput("midrst_no_eot",   64'(mon_pfd_eot + mon_phd_eot), 64'd0);
        checkOutput("midrst_no_valid", 64'(mon_pfd_val + mon_phd_val), 64'd0);
        checkOutput("midrst_no_rd",    64'(mon_pfd_rd + mon_phd_rd), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
